// File: rtl/gpio_pkg.sv
// Shared definitions for the gpio bank: register indices and bus direction
// encoding, reused by the soc address decoder and software headers.
package gpio_pkg;

  typedef enum logic [2:0] {
    REG_OUT    = 3'd0,
    REG_DIR    = 3'd1,
    REG_IN     = 3'd2,
    REG_IEN    = 3'd3,
    REG_RISE   = 3'd4,
    REG_FALL   = 3'd5,
    REG_PEND   = 3'd6,
    REG_TOGGLE = 3'd7
  } gpio_reg_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage input synchroniser for the pad inputs, plus a one-cycle-delayed
// copy of the synchronised value for edge detection.
module gpio_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gpin,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] prev
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] stage_d [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;

  always_comb begin
    stage_d[0] = gpin;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    prev_d = stage_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
      prev_q <= prev_d;
    end
  end

  assign sync = stage_q[SYNC_STAGES-1];
  assign prev = prev_q;

endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped bank of WIDTH gpio pins: direction/output registers, synchronised
// inputs, per-pin edge detection with maskable W1C pending bits and one irq line.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [63:0]       wdata,
  output logic [63:0]       rdata,
  output logic              rvalid,
  input  logic [WIDTH-1:0]  gpin,
  output logic [WIDTH-1:0]  gpout,
  output logic [WIDTH-1:0]  gpoe,
  output logic              irq
);

  localparam logic [2:0] SETTLE_MAX = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] out_q,  out_d;
  logic [WIDTH-1:0] dir_q,  dir_d;
  logic [WIDTH-1:0] ien_q,  ien_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [63:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic [2:0]       settle_q, settle_d;

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] ev;
  logic [63:0]      rd_val;
  gpio_reg_e        reg_sel;
  logic             settled;
  logic             wr_en;
  logic             rd_en;
  logic             unused_bus;

  gpio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .gpin(gpin),
    .sync(sync),
    .prev(prev)
  );

  assign reg_sel    = gpio_reg_e'(addr[5:3]);
  assign wd         = wdata[WIDTH-1:0];
  assign wr_en      = cs && (rw == RW_WRITE);
  assign rd_en      = cs && (rw == RW_READ);
  assign settled    = (settle_q == SETTLE_MAX);
  assign unused_bus = ^{addr, wdata};

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_OUT:  rd_val[WIDTH-1:0] = out_q;
      REG_DIR:  rd_val[WIDTH-1:0] = dir_q;
      REG_IN:   rd_val[WIDTH-1:0] = sync;
      REG_IEN:  rd_val[WIDTH-1:0] = ien_q;
      REG_RISE: rd_val[WIDTH-1:0] = rise_q;
      REG_FALL: rd_val[WIDTH-1:0] = fall_q;
      REG_PEND: rd_val[WIDTH-1:0] = pend_q;
      default:  rd_val = '0;
    endcase
  end

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    ien_d  = ien_q;
    rise_d = rise_q;
    fall_d = fall_q;
    w1c    = '0;
    if (wr_en) begin
      case (reg_sel)
        REG_OUT:    out_d  = wd;
        REG_DIR:    dir_d  = wd;
        REG_IEN:    ien_d  = wd;
        REG_RISE:   rise_d = wd;
        REG_FALL:   fall_d = wd;
        REG_PEND:   w1c    = wd;
        REG_TOGGLE: out_d  = out_q ^ wd;
        default:    ;
      endcase
    end

    // Events are held off until the synchroniser has flushed its reset zeros.
    ev       = settled ? ((sync & ~prev & rise_q) | (~sync & prev & fall_q)) : '0;
    pend_d   = (pend_q & ~w1c) | ev;
    settle_d = settled ? settle_q : settle_q + 3'd1;
    rvalid_d = rd_en;
    rdata_d  = rd_en ? rd_val : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= '0;
      dir_q    <= '0;
      ien_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      pend_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      settle_q <= '0;
    end else begin
      out_q    <= out_d;
      dir_q    <= dir_d;
      ien_q    <= ien_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      pend_q   <= pend_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      settle_q <= settle_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign gpout  = out_q;
  assign gpoe   = dir_q;
  assign irq    = |(pend_q & ien_q);

endmodule

// File: tb/tb_gpio_bank.sv
// Randomised self-checking bench for gpio_bank against a sample-history
// reference model, plus directed scenarios and a narrow WIDTH=8 instance.
module tb_gpio_bank;
  import gpio_pkg::*;

  localparam int W = 32;
  localparam int S = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs;
  logic [5:0]    addr;
  logic          rw;
  logic [63:0]   wdata;
  logic [63:0]   rdata;
  logic          rvalid;
  logic [W-1:0]  gpin;
  logic [W-1:0]  gpout;
  logic [W-1:0]  gpoe;
  logic          irq;

  logic          cs8;
  logic [5:0]    addr8;
  logic          rw8;
  logic [63:0]   wdata8;
  logic [63:0]   rdata8;
  logic          rvalid8;
  logic [7:0]    gpin8;
  logic [7:0]    gpout8;
  logic [7:0]    gpoe8;
  logic          irq8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gpio_bank #(.WIDTH(W), .SYNC_STAGES(S), .ADDR_W(6)) u_dut (
    .clk(clk), .rst(rst), .cs(cs), .addr(addr), .rw(rw), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .gpin(gpin), .gpout(gpout), .gpoe(gpoe), .irq(irq)
  );

  gpio_bank #(.WIDTH(8), .SYNC_STAGES(S), .ADDR_W(6)) u_dut8 (
    .clk(clk), .rst(rst), .cs(cs8), .addr(addr8), .rw(rw8), .wdata(wdata8),
    .rdata(rdata8), .rvalid(rvalid8), .gpin(gpin8), .gpout(gpout8), .gpoe(gpoe8), .irq(irq8)
  );

  // Reference model: register values plus a history of pad samples, one per edge.
  logic [W-1:0] m_out, m_dir, m_ien, m_rise, m_fall, m_pend;
  logic [63:0]  m_rdata;
  logic         m_rvalid;
  logic [W-1:0] m_hist [$];
  int           m_edges;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advances the model by one clock edge using the inputs currently applied.
  task automatic modelEdge();
    logic [W-1:0] sync_v, prev_v, ev, w1c, wd;
    if (rst) begin
      m_out = '0; m_dir = '0; m_ien = '0; m_rise = '0; m_fall = '0; m_pend = '0;
      m_rdata = '0; m_rvalid = 1'b0; m_edges = 0;
      m_hist = {};
      for (int i = 0; i <= S; i++) m_hist.push_back('0);
      return;
    end
    // History holds the last S+1 samples; the oldest two are prev and sync.
    sync_v = m_hist[1];
    prev_v = m_hist[0];
    ev = (m_edges >= S + 1) ? ((sync_v & ~prev_v & m_rise) | (~sync_v & prev_v & m_fall)) : '0;
    wd = wdata[W-1:0];
    w1c = '0;
    m_rvalid = 1'b0;
    if (cs) begin
      if (rw) begin
        case (addr[5:3])
          3'd0: m_out = wd;
          3'd1: m_dir = wd;
          3'd3: m_ien = wd;
          3'd4: m_rise = wd;
          3'd5: m_fall = wd;
          3'd6: w1c = wd;
          3'd7: m_out = m_out ^ wd;
          default: ;
        endcase
      end else begin
        m_rvalid = 1'b1;
        case (addr[5:3])
          3'd0: m_rdata = 64'(m_out);
          3'd1: m_rdata = 64'(m_dir);
          3'd2: m_rdata = 64'(sync_v);
          3'd3: m_rdata = 64'(m_ien);
          3'd4: m_rdata = 64'(m_rise);
          3'd5: m_rdata = 64'(m_fall);
          3'd6: m_rdata = 64'(m_pend);
          default: m_rdata = '0;
        endcase
      end
    end
    m_pend = (m_pend & ~w1c) | ev;
    m_hist.push_back(gpin);
    void'(m_hist.pop_front());
    if (m_edges < 1000) m_edges++;
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput("gpout", 64'(gpout), 64'(m_out));
    checkOutput("gpoe", 64'(gpoe), 64'(m_dir));
    checkOutput("irq", 64'(irq), 64'(|(m_pend & m_ien)));
    checkOutput("rvalid", 64'(rvalid), 64'(m_rvalid));
    checkOutput("rdata", rdata, m_rdata);
  endtask

  task automatic idle(input int n);
    cs = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic busWrite(input gpio_reg_e r, input logic [63:0] d);
    cs = 1'b1; rw = RW_WRITE; addr = {r, 3'($urandom)}; wdata = d;
    tick();
    cs = 1'b0;
  endtask

  task automatic busRead(input gpio_reg_e r, output logic [63:0] d);
    cs = 1'b1; rw = RW_READ; addr = {r, 3'($urandom)}; wdata = {$urandom, $urandom};
    tick();
    checkOutput("read_rvalid", 64'(rvalid), 64'd1);
    d = rdata;
    cs = 1'b0;
  endtask

  // Random bus traffic, pin activity and occasional resets.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      cs    = ($urandom_range(0, 1) == 1);
      rw    = ($urandom_range(0, 2) == 0);
      addr  = 6'($urandom);
      wdata = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) gpin = gpin ^ W'($urandom & $urandom);
      tick();
    end
    rst = 1'b0;
    cs  = 1'b0;
  endtask

  logic [63:0] d;
  int          n;

  initial begin
    rst = 1'b1; cs = 1'b0; rw = 1'b0; addr = '0; wdata = '0; gpin = '0;
    cs8 = 1'b0; rw8 = 1'b0; addr8 = '0; wdata8 = '0; gpin8 = '0;

    idle(3);
    checkOutput("reset_irq", 64'(irq), 64'd0);
    rst = 1'b0;
    for (int r = 0; r < 8; r++) begin
      busRead(gpio_reg_e'(r), d);
      checkOutput("reset_read", d, 64'd0);
    end
    idle(1);
    checkOutput("rvalid_drop", 64'(rvalid), 64'd0);

    // Pins high through reset must not produce rising events once enabled.
    gpin = '1; rst = 1'b1;
    idle(3);
    rst = 1'b0;
    busWrite(REG_RISE, '1);
    busWrite(REG_IEN, '1);
    idle(6);
    busRead(REG_PEND, d);
    checkOutput("settle_pend", d, 64'd0);
    checkOutput("settle_irq", 64'(irq), 64'd0);
    busWrite(REG_RISE, '0);
    busWrite(REG_IEN, '0);
    gpin = '0;
    idle(5);

    busWrite(REG_DIR, 64'hFF);
    busWrite(REG_OUT, 64'hA5);
    busWrite(REG_TOGGLE, 64'h0F);
    checkOutput("toggle_gpout", 64'(gpout), 64'hAA);
    checkOutput("dir_gpoe", 64'(gpoe), 64'hFF);
    busRead(REG_OUT, d);
    checkOutput("read_out", d, 64'hAA);
    busRead(REG_TOGGLE, d);
    checkOutput("read_toggle", d, 64'd0);

    busWrite(REG_RISE, 64'h1);
    busWrite(REG_IEN, 64'h1);
    gpin[0] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!irq && n < 10);
    checkOutput("rise_latency", 64'(n), 64'(S + 1));
    busRead(REG_IN, d);
    checkOutput("in_bit0", 64'(d[0]), 64'd1);
    busRead(REG_PEND, d);
    checkOutput("rise_pend", d, 64'h1);

    busWrite(REG_IEN, 64'h0);
    busWrite(REG_PEND, 64'h1);
    busWrite(REG_FALL, 64'h2);
    gpin[1] = 1'b1;
    idle(5);
    gpin[1] = 1'b0;
    idle(5);
    busRead(REG_PEND, d);
    checkOutput("fall_pend", d, 64'h2);
    checkOutput("fall_irq_masked", 64'(irq), 64'd0);
    busWrite(REG_IEN, 64'h2);
    checkOutput("fall_irq_unmasked", 64'(irq), 64'd1);
    busWrite(REG_PEND, 64'h2);
    checkOutput("w1c_irq", 64'(irq), 64'd0);
    busRead(REG_PEND, d);
    checkOutput("w1c_pend", d, 64'd0);

    // W1C lands on the same edge as a new rising event on pin 0.
    busWrite(REG_IEN, 64'h1);
    gpin[0] = 1'b0;
    idle(4);
    gpin[0] = 1'b1;
    idle(4);
    checkOutput("pre_collide_irq", 64'(irq), 64'd1);
    gpin[0] = 1'b0;
    idle(4);
    gpin[0] = 1'b1;
    idle(2);
    busWrite(REG_PEND, 64'h1);
    checkOutput("collide_irq", 64'(irq), 64'd1);
    busRead(REG_PEND, d);
    checkOutput("collide_pend", d, 64'h1);
    busWrite(REG_PEND, 64'h1);
    checkOutput("clear_irq", 64'(irq), 64'd0);

    busWrite(REG_OUT, 64'hFFFF_FFFF_1234_5678);
    busRead(REG_OUT, d);
    checkOutput("w32_mask", d, 64'h1234_5678);

    cs8 = 1'b1; rw8 = RW_WRITE; addr8 = {REG_OUT, 3'b000}; wdata8 = 64'hFFFF;
    tick();
    checkOutput("w8_gpout", 64'(gpout8), 64'hFF);
    rw8 = RW_READ;
    tick();
    cs8 = 1'b0;
    checkOutput("w8_rvalid", 64'(rvalid8), 64'd1);
    checkOutput("w8_rdata", rdata8, 64'hFF);

    // Reset wins over a concurrent read request.
    busWrite(REG_DIR, 64'h3C);
    cs = 1'b1; rw = RW_READ; addr = {REG_DIR, 3'b000}; rst = 1'b1;
    tick();
    checkOutput("rst_rvalid", 64'(rvalid), 64'd0);
    checkOutput("rst_rdata", rdata, 64'd0);
    checkOutput("rst_gpoe", 64'(gpoe), 64'd0);
    checkOutput("rst_gpout", 64'(gpout), 64'd0);
    checkOutput("rst_gpout8", 64'(gpout8), 64'd0);
    rst = 1'b0;
    busRead(REG_DIR, d);
    checkOutput("rst_dir", d, 64'd0);

    applyStimulus(2000);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
